axi_full_slave_mem: RTL and testbench

AXI4 full-protocol responder backed by an on-chip, byte-writable word memory. It is the slave end for axi_full_master and the simulation/FPGA target for cache line refills and writebacks. It handles one outstanding transaction at a time, supports INCR bursts of 1–256 beats, and returns OKAY or SLVERR per AXI rules.

---
 rtl/axi_pkg.sv | 15 +
 rtl/axi_slave_mem.sv | 29 ++
 rtl/axi_full_slave_mem.sv | 168 ++++++++++++++++
 tb/tb_axi_full_slave_mem.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI response codes and responder FSM states.
// Pure definitions: no latency or backpressure of its own.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WDATA,
      ST_WRESP,
      ST_RDATA
   } axi_state_t;

endpackage

// File: rtl/axi_slave_mem.sv
// Word memory with byte-enable synchronous write and combinational read.
// Write lands on the clock edge, read is same-cycle; never stalls.
module axi_slave_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [DATA_W-1:0]   wdat,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_W-1:0]   rdat
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
         if (we && wstrb[b]) begin
            mem[waddr][b*8 +: 8] <= wdat[b*8 +: 8];
         end
      end
   end

   assign rdat = mem[raddr];

endmodule

// File: rtl/axi_full_slave_mem.sv
// AXI4 INCR-burst responder over a byte-writable memory, one transaction in flight.
// First read beat the cycle after AR, then 1 beat/cycle; every channel stalls on VALID/READY.
module axi_full_slave_mem
   import axi_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_MEM_DEPTH        = 1024
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
   // One spare bit so a burst running past the top of the address space never wraps into range.
   localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB + 1;
   localparam int MEM_AW   = $clog2(C_MEM_DEPTH);
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(C_MEM_DEPTH);

   axi_state_t state, state_nxt;

   logic [IDX_W-1:0]              idx_q, idx_inc, aw_idx, ar_idx, rd_idx;
   logic [7:0]                    len_q, cnt_q, cnt_inc;
   logic                          err_q, w_err, last_beat, wr_in_range, rd_in_range;
   logic                          aw_hs, ar_hs, w_hs, r_hs, mem_we;
   logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdat, rd_word, rdata_q;
   logic [1:0]                    rd_resp, rresp_q, bresp_q;
   logic                          rlast_q;
   logic                          unused_addr_lsbs;

   assign aw_idx      = {1'b0, S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]};
   assign ar_idx      = {1'b0, S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]};
   assign idx_inc     = idx_q + IDX_W'(1);
   assign cnt_inc     = cnt_q + 8'd1;
   assign last_beat   = (cnt_q == len_q);
   assign rd_idx      = (state == ST_IDLE) ? ar_idx : idx_inc;
   assign wr_in_range = (idx_q < DEPTH_IDX);
   assign rd_in_range = (rd_idx < DEPTH_IDX);
   assign rd_word     = rd_in_range ? mem_rdat : '0;
   assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_SLVERR;
   assign w_err       = err_q | !wr_in_range | (S_AXI_WLAST != last_beat);

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
   assign r_hs   = S_AXI_RVALID  && S_AXI_RREADY;
   assign mem_we = w_hs && wr_in_range;

   assign unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   // Handshake outputs are held low while reset is asserted.
   always_comb begin
      state_nxt     = state;
      S_AXI_AWREADY = 1'b0;
      S_AXI_ARREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      S_AXI_RVALID  = 1'b0;
      if (S_AXI_ARESETN) begin
         case (state)
            ST_IDLE: begin
               S_AXI_AWREADY = 1'b1;
               S_AXI_ARREADY = !S_AXI_AWVALID;
               if (S_AXI_AWVALID)      state_nxt = ST_WDATA;
               else if (S_AXI_ARVALID) state_nxt = ST_RDATA;
            end
            ST_WDATA: begin
               S_AXI_WREADY = 1'b1;
               if (S_AXI_WVALID && last_beat) state_nxt = ST_WRESP;
            end
            ST_WRESP: begin
               S_AXI_BVALID = 1'b1;
               if (S_AXI_BREADY) state_nxt = ST_IDLE;
            end
            ST_RDATA: begin
               S_AXI_RVALID = 1'b1;
               if (S_AXI_RREADY && last_beat) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else if (aw_hs) begin
         idx_q <= aw_idx;
         len_q <= S_AXI_AWLEN;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (ar_hs) begin
         idx_q   <= ar_idx;
         len_q   <= S_AXI_ARLEN;
         cnt_q   <= '0;
         rdata_q <= rd_word;
         rresp_q <= rd_resp;
         rlast_q <= (S_AXI_ARLEN == 8'd0);
      end else if (w_hs) begin
         idx_q <= idx_inc;
         cnt_q <= cnt_inc;
         err_q <= w_err;
         if (last_beat) bresp_q <= w_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
         if (last_beat) begin
            rlast_q <= 1'b0;
         end else begin
            idx_q   <= idx_inc;
            cnt_q   <= cnt_inc;
            rdata_q <= rd_word;
            rresp_q <= rd_resp;
            rlast_q <= (cnt_inc == len_q);
         end
      end
   end

   assign S_AXI_RDATA = rdata_q;
   assign S_AXI_RRESP = rresp_q;
   assign S_AXI_RLAST = rlast_q;
   assign S_AXI_BRESP = bresp_q;

   axi_slave_mem #(
      .DATA_W (C_S_AXI_DATA_WIDTH),
      .DEPTH  (C_MEM_DEPTH)
   ) u_mem (
      .clk   (S_AXI_ACLK),
      .we    (mem_we),
      .waddr (idx_q[MEM_AW-1:0]),
      .wstrb (S_AXI_WSTRB),
      .wdat  (S_AXI_WDATA),
      .raddr (rd_idx[MEM_AW-1:0]),
      .rdat  (mem_rdat)
   );

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Bench for axi_full_slave_mem: directed cases plus random bursts against a word-array model.
module tb_axi_full_slave_mem;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int SW     = DW / 8;
   localparam int DEPTH  = 1024;
   localparam int BUDGET = 1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic          awvalid, awready, arvalid, arready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic          wlast, wvalid, wready;
   logic [1:0]    bresp, rresp;
   logic          bvalid, bready, rlast, rvalid, rready;

   int n_cmp = 0;
   int n_mis = 0;

   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] wq [$];
   logic [SW-1:0] sq [$];
   bit            lq [$];
   logic [DW-1:0] rq [$];
   logic [1:0]    rrq [$];

   always #5 clk = ~clk;

   axi_full_slave_mem #(
      .C_S_AXI_ADDR_WIDTH (AW),
      .C_S_AXI_DATA_WIDTH (DW),
      .C_MEM_DEPTH        (DEPTH)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWLEN   (awlen),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WLAST   (wlast),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARLEN   (arlen),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RLAST   (rlast),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input longint idx);
      return (idx < DEPTH) ? mem_m[int'(idx)] : '0;
   endfunction

   task automatic fill_beats(input int len, input bit rnd_strb);
      wq.delete(); sq.delete(); lq.delete();
      for (int i = 0; i <= len; i++) begin
         wq.push_back($urandom);
         sq.push_back(rnd_strb ? SW'($urandom) : '1);
         lq.push_back(i == len);
      end
   endtask

   task automatic one_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
      wq.delete(); sq.delete(); lq.delete();
      wq.push_back(d); sq.push_back(s); lq.push_back(1'b1);
   endtask

   task automatic aw_phase(input logic [AW-1:0] addr, input int len);
      bit hs = 0;
      int n  = 0;
      awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
      while (!hs && n < BUDGET) begin
         @(negedge clk); hs = awready;
         @(posedge clk); #1; n++;
      end
      awvalid = 1'b0;
      chk("aw_accept", hs, 1);
   endtask

   task automatic ar_phase(input logic [AW-1:0] addr, input int len, output int waited);
      bit hs = 0;
      int n  = 0;
      araddr = addr; arlen = 8'(len); arvalid = 1'b1;
      while (!hs && n < BUDGET) begin
         @(negedge clk); hs = arready;
         @(posedge clk); #1; n++;
      end
      arvalid = 1'b0;
      waited  = n;
      chk("ar_accept", hs, 1);
   endtask

   // Data beats then response; the model is updated per accepted beat.
   task automatic wb_phase(input logic [AW-1:0] addr, input int len, input bit gaps,
                           output logic [1:0] bresp_o);
      bit            err = 0;
      bit            hs;
      int            n, d;
      longint        idx;
      logic [DW-1:0] wd;
      logic [SW-1:0] ws;
      bresp_o = 2'bxx;
      for (int i = 0; i <= len; i++) begin
         while (gaps && $urandom_range(0, 3) == 0) begin
            wvalid = 1'b0; @(posedge clk); #1;
         end
         wd = wq[i]; ws = sq[i];
         wvalid = 1'b1; wdata = wd; wstrb = ws; wlast = lq[i];
         hs = 0; n = 0;
         while (!hs && n < BUDGET) begin
            @(negedge clk); hs = wready;
            if (arvalid) chk("ar_blocked_w", arready, 0);
            @(posedge clk); #1; n++;
         end
         chk("w_accept", hs, 1);
         if (!hs) begin
            wvalid = 1'b0;
            return;
         end
         idx = longint'(addr >> 2) + i;
         if (idx < DEPTH) begin
            for (int b = 0; b < SW; b++)
               if (ws[b]) mem_m[int'(idx)][8*b +: 8] = wd[8*b +: 8];
         end else begin
            err = 1;
         end
         if (lq[i] != (i == len)) err = 1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      d  = gaps ? $urandom_range(0, 3) : 0;
      hs = 0; n = 0;
      while (!hs && n < BUDGET) begin
         bready = (n >= d);
         @(negedge clk);
         if (arvalid) chk("ar_blocked_b", arready, 0);
         hs = bvalid && bready;
         if (hs) bresp_o = bresp;
         @(posedge clk); #1; n++;
      end
      bready = 1'b0;
      chk("b_accept", hs, 1);
      chk("b_resp", bresp_o, err ? 2'b10 : 2'b00);
   endtask

   task automatic r_phase(input logic [AW-1:0] addr, input int len, input int mode,
                          input int stop_after);
      int            beat = 0;
      int            cyc  = 0;
      bit            stalled = 0;
      logic [DW-1:0] hd;
      logic [1:0]    hr;
      logic          hl;
      longint        idx;
      rq.delete(); rrq.delete();
      while (beat <= len && beat != stop_after && cyc < BUDGET) begin
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (cyc % 3 == 0);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (cyc == 0) chk("r_first_vld", rvalid, 1);
         if (stalled) begin
            chk("r_hold_vld", rvalid, 1);
            chk("r_hold_data", rdata, hd);
            chk("r_hold_resp", rresp, hr);
            chk("r_hold_last", rlast, hl);
         end
         stalled = rvalid && !rready;
         hd = rdata; hr = rresp; hl = rlast;
         if (rvalid && rready) begin
            idx = longint'(addr >> 2) + beat;
            chk("r_data", rdata, exp_word(idx));
            chk("r_resp", rresp, (idx < DEPTH) ? 2'b00 : 2'b10);
            chk("r_last", rlast, beat == len);
            rq.push_back(rdata); rrq.push_back(rresp);
            beat++;
         end
         @(posedge clk); #1; cyc++;
      end
      rready = 1'b0;
      chk("r_beats", beat, (stop_after >= 0) ? stop_after : len + 1);
      if (stop_after < 0) chk("r_end_vld", rvalid, 0);
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input int len, input bit gaps,
                           output logic [1:0] br);
      aw_phase(addr, len);
      wb_phase(addr, len, gaps, br);
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
      int w;
      ar_phase(addr, len, w);
      r_phase(addr, len, mode, -1);
   endtask

   initial begin
      logic [1:0]    br;
      int            w, len, k;
      logic [AW-1:0] addr;

      rst_n = 1'b0;
      awaddr = '0; awlen = '0; awvalid = 1'b0;
      araddr = '0; arlen = '0; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("idle_awready", awready, 1);
      chk("idle_arready", arready, 1);
      @(posedge clk); #1;

      for (int blk = 0; blk < DEPTH / 256; blk++) begin
         fill_beats(255, 0);
         do_write(AW'(blk * 1024), 255, 0, br);
      end

      wq.delete(); sq.delete(); lq.delete();
      for (int i = 0; i < 4; i++) begin
         wq.push_back(DW'((i + 1) * 32'h11)); sq.push_back('1); lq.push_back(i == 3);
      end
      do_write(32'h40, 3, 0, br);
      chk("t1_bresp", br, 2'b00);
      do_read(32'h40, 3, 0);
      chk("t1_beat0", rq[0], 32'h11);
      chk("t1_beat1", rq[1], 32'h22);
      chk("t1_beat2", rq[2], 32'h33);
      chk("t1_beat3", rq[3], 32'h44);

      one_beat(32'h12345678, 4'hF);
      do_write(32'h0, 0, 0, br);
      one_beat(32'hAABBCCDD, 4'h3);
      do_write(32'h0, 0, 0, br);
      do_read(32'h0, 0, 0);
      chk("strb_merge", rq[0], 32'h1234CCDD);

      do_read(32'h80, 7, 1);

      fill_beats(1, 0);
      awaddr = 32'h100; awlen = 8'd1; awvalid = 1'b1;
      araddr = 32'h100; arlen = 8'd1; arvalid = 1'b1;
      @(negedge clk);
      chk("collide_awready", awready, 1);
      chk("collide_arready", arready, 0);
      @(posedge clk); #1; awvalid = 1'b0;
      wb_phase(32'h100, 1, 0, br);
      ar_phase(32'h100, 1, w);
      chk("ar_after_b", w, 1);
      r_phase(32'h100, 1, 0, -1);

      do_read(AW'((DEPTH - 2) * 4), 3, 0);
      chk("oor_rresp1", rrq[1], 2'b00);
      chk("oor_rdata2", rq[2], 0);
      chk("oor_rresp3", rrq[3], 2'b10);

      fill_beats(3, 0);
      lq[1] = 1'b1; lq[3] = 1'b0;
      do_write(32'h200, 3, 0, br);
      chk("early_wlast", br, 2'b10);

      ar_phase(32'h300, 7, w);
      r_phase(32'h300, 7, 0, 1);
      rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("abort_rvalid", rvalid, 0);
      chk("abort_arready", arready, 1);
      chk("abort_rlast", rlast, 0);
      @(posedge clk); #1;
      do_read(32'h300, 7, 0);

      for (int t = 0; t < 40; t++) begin
         len = $urandom_range(0, 15);
         if ($urandom_range(0, 9) == 0) addr = 32'h0010_0000 + AW'($urandom_range(0, 255));
         else                           addr = AW'($urandom_range(0, DEPTH * 4 - 1));
         if ($urandom_range(0, 1) == 1) begin
            fill_beats(len, 1);
            if ($urandom_range(0, 4) == 0) begin
               k = $urandom_range(0, len);
               lq[k] = !lq[k];
            end
            do_write(addr, len, 1, br);
         end else begin
            do_read(addr, len, $urandom_range(0, 2));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
